// File: rtl/tcm_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// tcm_load_ctrl_if
// Bus bundle between the TCM loader and its surroundings.
//   AHB-style read side : ahb_req/ahb_addr/ahb_ready (address phase),
//                         ahb_rdata/ahb_rvalid/ahb_rerr (data phase, in order)
//   TCM write side      : tcm_wen/tcm_waddr/tcm_wdata (full-word writes)
// Modports:
//   master - the loader (drives requests and TCM writes)
//   slave  - the bus/TCM side (drives ready and read data)
// ---------------------------------------------------------------------------
interface tcm_load_ctrl_if;
  logic        ahb_req;
  logic [31:0] ahb_addr;
  logic        ahb_ready;
  logic [31:0] ahb_rdata;
  logic        ahb_rvalid;
  logic        ahb_rerr;
  logic        tcm_wen;
  logic [12:0] tcm_waddr;
  logic [31:0] tcm_wdata;

  modport master (
    output ahb_req, ahb_addr, tcm_wen, tcm_waddr, tcm_wdata,
    input  ahb_ready, ahb_rdata, ahb_rvalid, ahb_rerr
  );

  modport slave (
    input  ahb_req, ahb_addr, tcm_wen, tcm_waddr, tcm_wdata,
    output ahb_ready, ahb_rdata, ahb_rvalid, ahb_rerr
  );
endinterface

// File: rtl/tcm_load_ctrl.sv
// ---------------------------------------------------------------------------
// tcm_load_ctrl
// Copies SIZE bytes from the bus, starting at SRC_BASE, into the TCM one
// 32-bit word at a time. At most two reads are kept in flight. An error
// response aborts the load: remaining in-flight beats are drained and
// discarded before returning to idle.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rstn   - asynchronous active-low reset
//   start  - load request pulse, ignored while busy
//   bus    - tcm_load_ctrl_if.master: read requests, read data, TCM writes
//   busy   - load in progress (TCM owned by the loader)
//   done   - sticky, last load completed cleanly
//   err    - sticky, last load ended on an error response
// ---------------------------------------------------------------------------
module tcm_load_ctrl #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] SIZE       = 32'h0000_8000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  tcm_load_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // tcm_waddr is already relative to START_ADDR, so the base only has to be
  // word aligned; SIZE must be whole words and fit the 32 KiB TCM.
  if ((SIZE[1:0] != 2'b00) || (SIZE > 32'h0000_8000) ||
      (START_ADDR[1:0] != 2'b00)) begin : g_param_check
    $error("tcm_load_ctrl: SIZE must be a word multiple <= 32'h8000, START_ADDR word aligned");
  end

  localparam logic [13:0] NWORDS = SIZE[15:2];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [13:0] issue_cnt;
  logic [13:0] wr_cnt;
  logic [1:0]  outst;
  logic        auto_pend;

  logic        beat_vld;
  logic        beat_good;
  logic        beat_bad;
  logic        accept;
  logic [1:0]  outst_nxt;

  // A beat only counts when something is in flight; stray beats (e.g. ones
  // belonging to a load killed by reset) fall through untouched.
  assign beat_vld  = bus.ahb_rvalid && (outst != 2'd0);
  assign beat_good = beat_vld && !bus.ahb_rerr && (state == S_LOAD);
  assign beat_bad  = beat_vld &&  bus.ahb_rerr && (state == S_LOAD);

  // Request is a pure function of registered state, so it and the address
  // hold steady until accepted.
  assign bus.ahb_req  = (state == S_LOAD) && (issue_cnt < NWORDS) && (outst < 2'd2);
  assign bus.ahb_addr = SRC_BASE + {16'd0, issue_cnt, 2'b00};
  assign accept       = bus.ahb_req && bus.ahb_ready;

  // Good beats go straight through to the TCM in the same cycle.
  assign bus.tcm_wen   = beat_good;
  assign bus.tcm_waddr = wr_cnt[12:0];
  assign bus.tcm_wdata = bus.ahb_rdata;

  always_comb begin
    outst_nxt = outst;
    if (accept && !beat_vld) begin
      outst_nxt = outst + 2'd1;
    end else if (!accept && beat_vld) begin
      outst_nxt = outst - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      issue_cnt <= 14'd0;
      wr_cnt    <= 14'd0;
      outst     <= 2'd0;
      auto_pend <= AUTO_START;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Auto start is offered only in the first cycle after reset release.
      auto_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || auto_pend) begin
            done      <= 1'b0;
            err       <= 1'b0;
            issue_cnt <= 14'd0;
            wr_cnt    <= 14'd0;
            outst     <= 2'd0;
            if (NWORDS == 14'd0) begin
              // Nothing to copy: report completion without touching the bus.
              done <= 1'b1;
            end else begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          outst <= outst_nxt;
          if (accept) begin
            issue_cnt <= issue_cnt + 14'd1;
          end
          if (beat_bad) begin
            err <= 1'b1;
            // A request accepted in this same cycle still has a beat coming.
            if (outst_nxt == 2'd0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
          end else if (beat_good) begin
            wr_cnt <= wr_cnt + 14'd1;
            if ((wr_cnt + 14'd1) == NWORDS) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          outst <= outst_nxt;
          if (outst_nxt == 2'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tcm_load_ctrl
// Three loader instances:
//   dut_a : 4 words from 0x1000, manual start  (table + random loads)
//   dut_b : zero-length load, auto start
//   dut_c : 8 words from 0x2000, auto start    (reset mid-load)
// dut_a is driven by a bus responder with configurable ready rate, read
// latency, beat rate and error injection; a transaction-level model tracks
// issued/returned/written words and the sticky flags.
// ---------------------------------------------------------------------------
module tb_tcm_load_ctrl;

  localparam logic [31:0] SRC_A = 32'h0000_1000;
  localparam int          NA    = 4;
  localparam logic [31:0] SRC_C = 32'h0000_2000;
  localparam int          NC    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a = 1'b0, rstn_b = 1'b0, rstn_c = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;
  logic busy_c, done_c, err_c;

  tcm_load_ctrl_if ifa ();
  tcm_load_ctrl_if ifb ();
  tcm_load_ctrl_if ifc ();

  tcm_load_ctrl #(.START_ADDR(32'h0), .SRC_BASE(SRC_A), .SIZE(32'd16), .AUTO_START(1'b0)) dut_a (
    .clk(clk), .rstn(rstn_a), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .err(err_a));

  tcm_load_ctrl #(.START_ADDR(32'h0), .SRC_BASE(32'h0000_3000), .SIZE(32'd0), .AUTO_START(1'b1)) dut_b (
    .clk(clk), .rstn(rstn_b), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .err(err_b));

  tcm_load_ctrl #(.START_ADDR(32'h0), .SRC_BASE(SRC_C), .SIZE(32'd32), .AUTO_START(1'b1)) dut_c (
    .clk(clk), .rstn(rstn_c), .start(start_c), .bus(ifc),
    .busy(busy_c), .done(done_c), .err(err_c));

  int n_chk = 0;
  int n_err = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;

  typedef struct {
    int ready_pct;
    int lat;
    int rv_pct;
    int err_beat;
    int stall_idx;
    int stall_len;
    int start_mid;
    int exp_wr;
    bit exp_done;
    bit exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          idx;
  } beat_t;

  vec_t vecs [7];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete load on dut_a; called at posedge+1 with dut_a idle.
  task automatic run_load(input vec_t v, input string tag);
    beat_t pend[$];
    beat_t b;
    int    issued, outst, wcnt, nwr, stall_left;
    bit    active, err_seen, req_e, wen_e, fin;
    issued = 0; outst = 0; wcnt = 0; nwr = 0; stall_left = v.stall_len;
    active = 1'b0; err_seen = 1'b0; fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      start_a = (k == 0) || ((v.start_mid != 0) && (k == 4));
      req_e = active && !err_seen && (issued < NA) && (outst < 2);
      if (stall_left > 0 && issued == v.stall_idx && req_e) begin
        ifa.ahb_ready = 1'b0;
        stall_left--;
      end else begin
        ifa.ahb_ready = (int'($urandom_range(99)) < v.ready_pct);
      end
      if (pend.size() > 0 && pend[0].due <= k && int'($urandom_range(99)) < v.rv_pct) begin
        ifa.ahb_rvalid = 1'b1;
        ifa.ahb_rdata  = word_of(pend[0].addr);
        ifa.ahb_rerr   = (pend[0].idx == v.err_beat);
      end else begin
        ifa.ahb_rvalid = 1'b0;
        ifa.ahb_rdata  = $urandom;
        ifa.ahb_rerr   = 1'($urandom_range(1));
      end
      wen_e = ifa.ahb_rvalid && !ifa.ahb_rerr && active && !err_seen;
      #1;
      chk({tag, ".req"}, ifa.ahb_req, req_e);
      if (req_e) chk({tag, ".addr"}, ifa.ahb_addr, SRC_A + 32'(4 * issued));
      chk({tag, ".wen"}, ifa.tcm_wen, wen_e);
      if (wen_e) begin
        chk({tag, ".waddr"}, ifa.tcm_waddr, wcnt);
        chk({tag, ".wdata"}, ifa.tcm_wdata, word_of(SRC_A + 32'(4 * wcnt)));
      end
      chk({tag, ".busy"}, busy_a, active);
      chk({tag, ".done"}, done_a, m_done);
      chk({tag, ".err"}, err_a, m_err);
      if (ifa.tcm_wen) nwr++;
      // Model update for the coming clock edge.
      if (!active) begin
        if (start_a) begin
          active = 1'b1; m_done = 1'b0; m_err = 1'b0;
          issued = 0; outst = 0; wcnt = 0; err_seen = 1'b0;
        end
      end else begin
        if (ifa.ahb_req && ifa.ahb_ready) begin
          b.addr = ifa.ahb_addr; b.due = k + v.lat; b.idx = issued;
          pend.push_back(b);
          issued++; outst++;
        end
        if (ifa.ahb_rvalid) begin
          b = pend.pop_front();
          outst--;
          if (ifa.ahb_rerr) begin err_seen = 1'b1; m_err = 1'b1; end
          else wcnt++;
        end
        chk({tag, ".outst_over2"}, 32'(outst > 2), 32'd0);
        if (!err_seen && wcnt == NA) begin
          active = 1'b0; m_done = 1'b1;
        end else if (err_seen && outst == 0) begin
          active = 1'b0;
        end
      end
      if (k > 0 && !active && pend.size() == 0) fin = 1'b1;
      tick();
    end
    start_a = 1'b0;
    ifa.ahb_rvalid = 1'b0;
    ifa.ahb_ready  = 1'b0;
    n_chk++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s.timeout: load still running after 300 cycles", tag);
    end
    #1;
    chk({tag, ".final_busy"}, busy_a, 1'b0);
    chk({tag, ".final_req"}, ifa.ahb_req, 1'b0);
    chk({tag, ".final_done"}, done_a, v.exp_done);
    chk({tag, ".final_err"}, err_a, v.exp_err);
    chk({tag, ".writes"}, nwr, v.exp_wr);
    tick();
  endtask

  // dut_c responder: ready always, data one cycle after accept; stops after
  // max_wr TCM writes have been seen.
  task automatic c_run(input int max_wr, output int nwr);
    beat_t pc[$];
    beat_t b;
    int    issued, cyc;
    issued = 0; nwr = 0; cyc = 0;
    while (nwr < max_wr && cyc < 100) begin
      ifc.ahb_ready = 1'b1;
      if (pc.size() > 0) begin
        ifc.ahb_rvalid = 1'b1; ifc.ahb_rdata = word_of(pc[0].addr); ifc.ahb_rerr = 1'b0;
      end else begin
        ifc.ahb_rvalid = 1'b0; ifc.ahb_rdata = $urandom; ifc.ahb_rerr = 1'b0;
      end
      #1;
      chk("c.wen", ifc.tcm_wen, ifc.ahb_rvalid);
      if (ifc.ahb_req) chk("c.addr", ifc.ahb_addr, SRC_C + 32'(4 * issued));
      if (ifc.tcm_wen) begin
        chk("c.waddr", ifc.tcm_waddr, nwr);
        chk("c.wdata", ifc.tcm_wdata, word_of(SRC_C + 32'(4 * nwr)));
        nwr++;
      end
      if (ifc.ahb_req && ifc.ahb_ready) begin
        b.addr = ifc.ahb_addr; b.due = cyc; b.idx = issued;
        pc.push_back(b);
        issued++;
      end
      if (ifc.ahb_rvalid) b = pc.pop_front();
      tick();
      cyc++;
    end
    ifc.ahb_rvalid = 1'b0;
    ifc.ahb_ready  = 1'b0;
    n_chk++;
    if (cyc >= 100) begin
      n_err++;
      $display("FAIL c.timeout: wrote %0d words, required %0d", nwr, max_wr);
    end
  endtask

  initial begin
    vec_t v;
    int   nwr;
    //              rdy lat rv  errb stl_i stl_n mid wr done err
    vecs[0] = '{100, 1, 100, -1, -1, 0, 0, 4, 1'b1, 1'b0};  // back-to-back
    vecs[1] = '{100, 1, 100, -1,  1, 3, 0, 4, 1'b1, 1'b0};  // 2nd request stalled 3 cycles
    vecs[2] = '{100, 2, 100,  2, -1, 0, 0, 2, 1'b0, 1'b1};  // error on beat 2, 2 in flight
    vecs[3] = '{100, 1, 100, -1, -1, 0, 1, 4, 1'b1, 1'b0};  // start pulse mid-load
    vecs[4] = '{100, 1, 100, -1, -1, 0, 0, 4, 1'b1, 1'b0};  // restart after done
    vecs[5] = '{100, 3, 100,  0, -1, 0, 0, 0, 1'b0, 1'b1};  // error on first beat
    vecs[6] = '{ 50, 3,  60,  3, -1, 0, 0, 3, 1'b0, 1'b1};  // error on last beat, slow bus

    ifa.ahb_ready = 1'b0; ifa.ahb_rvalid = 1'b0; ifa.ahb_rdata = 32'h0; ifa.ahb_rerr = 1'b0;
    ifb.ahb_ready = 1'b0; ifb.ahb_rvalid = 1'b0; ifb.ahb_rdata = 32'h0; ifb.ahb_rerr = 1'b0;
    ifc.ahb_ready = 1'b0; ifc.ahb_rvalid = 1'b0; ifc.ahb_rdata = 32'h0; ifc.ahb_rerr = 1'b0;

    repeat (3) tick();
    #1;
    chk("rst_a.req",  ifa.ahb_req, 1'b0);
    chk("rst_a.wen",  ifa.tcm_wen, 1'b0);
    chk("rst_a.busy", busy_a, 1'b0);
    chk("rst_a.done", done_a, 1'b0);
    chk("rst_a.err",  err_a, 1'b0);
    chk("rst_a.addr", ifa.ahb_addr, SRC_A);
    chk("rst_c.addr", ifc.ahb_addr, SRC_C);
    chk("rst_c.busy", busy_c, 1'b0);
    tick();

    // Release a (manual start) and b (empty auto load).
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b.req",  ifb.ahb_req, 1'b0);
      chk("b.wen",  ifb.tcm_wen, 1'b0);
      chk("b.busy", busy_b, 1'b0);
      if (i == 0) chk("b.done_early", done_b, 1'b0);
      if (i >= 2) chk("b.done", done_b, 1'b1);
      chk("a.no_autostart_busy", busy_a, 1'b0);
      chk("a.no_autostart_req",  ifa.ahb_req, 1'b0);
      tick();
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    #1;
    chk("b.start_busy", busy_b, 1'b0);
    chk("b.start_done", done_b, 1'b1);
    chk("b.start_req",  ifb.ahb_req, 1'b0);
    tick();

    for (int i = 0; i < 7; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      v.ready_pct = int'($urandom_range(100, 30));
      v.lat       = int'($urandom_range(4, 1));
      v.rv_pct    = int'($urandom_range(100, 40));
      v.err_beat  = ($urandom_range(3) == 0) ? int'($urandom_range(NA - 1)) : -1;
      v.stall_idx = int'($urandom_range(NA - 1));
      v.stall_len = int'($urandom_range(3));
      v.start_mid = (v.err_beat < 0) ? int'($urandom_range(1)) : 0;
      v.exp_wr    = (v.err_beat < 0) ? NA : v.err_beat;
      v.exp_done  = (v.err_beat < 0);
      v.exp_err   = (v.err_beat >= 0);
      run_load(v, $sformatf("rnd%0d", i));
    end

    // dut_c: auto load, reset after two words, stray beat, full reload.
    rstn_c = 1'b1;
    c_run(2, nwr);
    chk("c.first_writes", nwr, 2);
    rstn_c = 1'b0;
    #1;
    chk("c.rst_req",  ifc.ahb_req, 1'b0);
    chk("c.rst_wen",  ifc.tcm_wen, 1'b0);
    chk("c.rst_busy", busy_c, 1'b0);
    chk("c.rst_done", done_c, 1'b0);
    chk("c.rst_err",  err_c, 1'b0);
    chk("c.rst_addr", ifc.ahb_addr, SRC_C);
    tick();
    rstn_c = 1'b1;
    ifc.ahb_rvalid = 1'b1; ifc.ahb_rerr = 1'b0; ifc.ahb_rdata = $urandom;
    #1;
    chk("c.stray_wen",  ifc.tcm_wen, 1'b0);
    chk("c.stray_busy", busy_c, 1'b0);
    tick();
    ifc.ahb_rvalid = 1'b0;
    c_run(NC, nwr);
    chk("c.reload_writes", nwr, NC);
    #1;
    chk("c.done", done_c, 1'b1);
    chk("c.err",  err_c, 1'b0);
    chk("c.busy", busy_c, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c.once_busy", busy_c, 1'b0);
      chk("c.once_req",  ifc.ahb_req, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tcm_load_ctrl.md
TCM_LOAD_CTRL -- requirements
Module: tcm_load_ctrl

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h0000_0000: TCM base address; tcm_waddr is relative to it.
REQ-002 SHALL have parameter SRC_BASE, default 32'h0000_0000: bus address of the first source word.
REQ-003 SHALL have parameter SIZE, default 32'h8000: load length in bytes; multiple of 4; at most 32'h8000.
REQ-004 SHALL have parameter AUTO_START, default 1: start a load automatically after reset release.
REQ-005 SHALL have clk  input  1  clock; single clock domain; all state on rising edge.
REQ-006 SHALL have rstn  input  1  reset, asynchronous assert, active low.
REQ-007 SHALL have start  input  1  load request pulse; ignored while busy=1.
REQ-008 SHALL have ahb_req  output  1  read address-phase request.
REQ-009 SHALL have ahb_addr  output  32  read address; valid when ahb_req=1.
REQ-010 SHALL have ahb_ready  input  1  address accepted when ahb_req&ahb_ready.
REQ-011 SHALL have ahb_rdata  input  32  read data.
REQ-012 SHALL have ahb_rvalid  input  1  read data valid, one per accepted address, in order.
REQ-013 SHALL have ahb_rerr  input  1  error response; qualified by ahb_rvalid.
REQ-014 SHALL have tcm_wen  output  1  TCM word write enable, full-word strobe.
REQ-015 SHALL have tcm_waddr  output  13  TCM word index (byte offset / 4).
REQ-016 SHALL have tcm_wdata  output  32  TCM write data.
REQ-017 SHALL have busy  output  1  load in progress; TCM must not be used by other ports.
REQ-018 SHALL have done  output  1  sticky: last load completed without error.
REQ-019 SHALL have err  output  1  sticky: last load terminated by error response.

Function
REQ-020 SHALL implement FSM IDLE, LOAD, DRAIN.
REQ-021 IDLE->LOAD SHALL occur on start=1, or on the first cycle after reset when AUTO_START=1; entry SHALL clear done and err, and zero the issue count, write count and outstanding counter.
REQ-022 SIZE=0: a start SHALL raise done in the next cycle without any ahb_req or tcm_wen; busy SHALL stay 0.
REQ-023 In LOAD, ahb_req SHALL be 1 while issue count < SIZE/4 and outstanding < 2.
REQ-024 ahb_addr SHALL equal SRC_BASE + 4*issue count.
REQ-025 Each accepted request SHALL increment the issue count.
REQ-026 The outstanding counter (0..2) SHALL be +1 on accept, -1 on ahb_rvalid, and unchanged when both occur in the same cycle.
REQ-027 ahb_rvalid with ahb_rerr=0 SHALL produce a combinational tcm_wen=1 in the same cycle, with tcm_wdata=ahb_rdata and tcm_waddr=write count[12:0].
REQ-028 The write count SHALL increment on each such good beat.
REQ-029 A good beat SHALL write data at word write count; the first beat SHALL write word 0 and the last word (SIZE/4-1) SHALL be written exactly once.
REQ-030 When the write count reaches SIZE/4, the FSM SHALL go to IDLE and set done=1 in the next cycle.
REQ-031 ahb_rvalid with ahb_rerr=1 SHALL suppress tcm_wen, set err=1, block further ahb_req, and move the FSM to DRAIN.
REQ-032 DRAIN SHALL discard remaining beats (no tcm_wen) and go to IDLE when outstanding reaches 0.
REQ-033 busy SHALL be 1 in LOAD and DRAIN, and 0 in IDLE.
REQ-034 ahb_req SHALL never be asserted in IDLE or DRAIN.
REQ-035 Once asserted, ahb_req and ahb_addr SHALL hold stable until accepted, unless an error moves the FSM to DRAIN.
REQ-036 ahb_rvalid with outstanding=0 SHALL be ignored (no write, no count change).
REQ-037 start during LOAD or DRAIN SHALL have no effect; start in the cycle the FSM enters IDLE SHALL be honoured on the next cycle.

Reset
REQ-038 On rstn=0 the FSM SHALL enter IDLE and all counters SHALL clear to 0.
REQ-039 During reset, ahb_req, tcm_wen, busy, done and err SHALL be 0, and ahb_addr SHALL equal SRC_BASE.
REQ-040 Reset asserted mid-load SHALL abandon the load immediately, and beats arriving after reset release SHALL be ignored per REQ-036.
REQ-041 With AUTO_START=1, LOAD SHALL be entered exactly once per reset release.

Verification
REQ-042 SIZE=16, SRC_BASE=32'h1000, ahb_ready=1, rvalid one cycle after accept -> addresses 1000/1004/1008/100C, tcm_waddr 0..3, done=1 one cycle after the 4th write, busy=0.
REQ-043 ahb_ready held 0 for 3 cycles on the second request -> ahb_addr stays 32'h1004 and stable; outstanding never exceeds 2; all 4 words written in order.
REQ-044 Beat 2 of 4 returns ahb_rerr=1 while 2 outstanding -> words 0..1 written, no further tcm_wen, err=1, done=0, busy falls after the last outstanding beat.
REQ-045 SIZE=0, AUTO_START=1 -> done=1 two cycles after reset release; ahb_req never asserted.
REQ-046 rstn pulsed low after 2 of 8 words, followed by a stray ahb_rvalid -> no tcm_wen, reload restarts at SRC_BASE, tcm_waddr starts at 0.
REQ-047 start pulsed during LOAD, then again after done -> first pulse ignored; second pulse clears done and reloads all words.
